spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock, rising-edge active; one clock domain only.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sclk, input, 1, SPI serial clock, asynchronous to clk; clk SHALL be at least 4x sclk.
REQ-004 SHALL have port ss, input, 1, slave select, active-high (1 = transfer in progress), asynchronous.
REQ-005 SHALL have port mosi, input, 1, serial data, MSB first, asynchronous.
REQ-006 SHALL have port rx_data, output, 8, last completed byte, held until next completion.
REQ-007 SHALL have port rx_valid, output, 1, one-clk pulse marking a new rx_data.
REQ-008 SHALL have port frame_err, output, 1, one-clk pulse on ss deassert mid-byte.
REQ-009 SHALL have port busy, output, 1, high while state is not IDLE.
REQ-010 With SPI_SLAVE_MISO_EN, SHALL add ports tx_data (input, 8), tx_load (input, 1), miso (output, 1) and tx_ready (output, 1).

Function
REQ-011 SHALL pass sclk, ss and mosi through a 2-flop synchronizer, then a 1-flop edge register.
REQ-012 SHALL operate in SPI mode 0: sample mosi on the sclk rising edge; with MISO enabled, shift miso on the sclk falling edge.
REQ-013 SHALL implement the FSM IDLE -> SHIFT -> DONE. IDLE->SHIFT on synchronized ss rising. SHIFT->DONE on the 8th sampled bit. DONE->SHIFT on the next cycle if ss is still high, else DONE->IDLE. SHIFT->IDLE on ss falling.
REQ-014 Bit counter SHALL be 3 bits, cleared on entry to SHIFT, incremented per sampled bit, and wrap 7->0 on byte completion.
REQ-015 Shift register SHALL shift left, inserting the sampled mosi at bit 0.
REQ-016 rx_data SHALL load and rx_valid SHALL pulse in the cycle after the 8th sampled edge is detected, i.e. 4 clk edges after clk first samples the 8th sclk high.
REQ-017 Multiple bytes per ss assertion SHALL be supported back-to-back with no dropped bits.
REQ-018 If ss falls with 1..7 bits sampled: partial byte discarded, rx_data unchanged, frame_err pulses one cycle, FSM -> IDLE.
REQ-019 If ss falls with 0 bits sampled, or in the same cycle as the 8th-bit detection: byte completes normally, no frame_err.
REQ-020 sclk edges while ss is low SHALL be ignored.
REQ-021 With MISO enabled: tx_load with tx_ready high captures tx_data. The captured byte is shifted MSB first starting at ss rise. tx_ready drops on capture and rises at byte completion. With no byte loaded, miso drives 0. tx_load while tx_ready is low is ignored.

Reset
REQ-022 While rst = 0: rx_data = 8'h00, rx_valid = 0, frame_err = 0, busy = 0, miso = 0, tx_ready = 1, counter = 0, synchronizer flops = 0, state = IDLE.
REQ-023 Reset mid-transfer SHALL abort immediately with no rx_valid or frame_err on release; reception resumes at the next ss rising edge.

Configuration
REQ-024 Macro SPI_SLAVE_MISO_EN SHALL compile in the MISO transmit path per REQ-010 and REQ-021; when undefined, those ports and that logic SHALL be absent and receive behaviour SHALL be identical.

Structure
REQ-025 Package spi_pkg SHALL hold the FSM state encoding (IDLE=0, SHIFT=1, DONE=2) and the constant SPI_DATA_W = 8.
REQ-026 Sub-module spi_sync SHALL implement the 2-flop synchronizer, instantiated once per async input.

Verification
REQ-027 Reset with rst=0, then release; ss=1, clk = 8x sclk, shift 8'hA5 -> one rx_valid pulse, rx_data = 8'hA5, busy returns low after ss=0.
REQ-028 Three back-to-back bytes 8'h01, 8'h80, 8'hFF under one ss assertion -> three rx_valid pulses carrying those values in order; frame_err stays 0.
REQ-029 Shift 5 bits of 8'h3C, then ss=0 -> frame_err pulses once, no rx_valid, rx_data keeps its previous value.
REQ-030 Toggle sclk with ss=0 and mosi=1 for 16 edges -> no rx_valid, busy = 0.
REQ-031 rst=0 asserted after 4 bits, released, then a full 8'h5A transfer -> only one rx_valid, with data 8'h5A.
REQ-032 With SPI_SLAVE_MISO_EN: tx_load with 8'hC3, master sends 8'h00 -> miso bits 1,1,0,0,0,0,1,1 on successive sclk falls; tx_ready rises with rx_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receiver: data width, bit counter width
// and the receive FSM state encoding.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Two-flop synchronizer that brings one asynchronous input into the clk domain.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset (both flops clear to 0)
//   d_i  - asynchronous input
//   q_o  - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 slave receiver. sclk, ss and mosi are synchronized into the clk
// domain, sclk/ss edges are found with a one-flop edge register, and an
// IDLE -> SHIFT -> DONE FSM assembles MSB-first bytes. Several bytes may be
// received back-to-back under one ss assertion.
//
// Optional feature (macro SPI_SLAVE_MISO_EN): MISO transmit path. A byte is
// captured with tx_load while tx_ready is high and shifted out MSB first from
// the ss rising edge, changing on sclk falling edges.
//
// Ports:
//   clk       - system clock, rising edge (at least 4x sclk)
//   rst       - asynchronous active-low reset
//   sclk      - SPI serial clock (async)
//   ss        - slave select, active-high (async)
//   mosi      - serial data in, MSB first (async)
//   tx_data   - [MISO only] byte to transmit
//   tx_load   - [MISO only] capture tx_data when tx_ready is high
//   miso      - [MISO only] serial data out
//   tx_ready  - [MISO only] transmit buffer free
//   rx_data   - last completed byte, held until the next completion
//   rx_valid  - one-clk pulse marking new rx_data
//   frame_err - one-clk pulse when ss drops with 1..7 bits sampled
//   busy      - high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module spi_slave_rx
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
`ifdef SPI_SLAVE_MISO_EN
    input  logic [SPI_DATA_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  miso,
    output logic                  tx_ready,
`endif
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    logic sclk_s, ss_s, mosi_s;
    logic sclk_e_q, ss_e_q;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_state_e              state_q, state_d;
    logic [SPI_CNT_W-1:0]    cnt_q, cnt_d;
    logic [SPI_DATA_W-1:0]   sh_q, sh_d;
    logic [SPI_DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;

    spi_sync u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
    spi_sync u_sync_ss   (.clk(clk), .rst(rst), .d_i(ss),   .q_o(ss_s));
    spi_sync u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

    assign sclk_rise =  sclk_s & ~sclk_e_q;
    assign sclk_fall = ~sclk_s &  sclk_e_q;
    assign ss_rise   =  ss_s   & ~ss_e_q;
    assign ss_fall   = ~ss_s   &  ss_e_q;

`ifdef SPI_SLAVE_MISO_EN
    logic [SPI_DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [SPI_DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic                  tx_pend_q, tx_pend_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  tx_start;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // sclk activity is ignored here, so edges with ss low do nothing
                if (ss_rise) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // The 8th bit wins over a simultaneous ss fall: the byte completes
                if (sclk_rise && cnt_q == 3'd7) begin
                    sh_d    = {sh_q[SPI_DATA_W-2:0], mosi_s};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = DONE;
                end else if (ss_fall) begin
                    frame_err_d = (cnt_q != 3'd0) | sclk_rise;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    sh_d  = {sh_q[SPI_DATA_W-2:0], mosi_s};
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                rx_data_d  = sh_q;
                rx_valid_d = 1'b1;
                // Keep sampling so a fast following byte loses no bits
                if (sclk_rise) begin
                    sh_d  = {sh_q[SPI_DATA_W-2:0], mosi_s};
                    cnt_d = cnt_q + 3'd1;
                end
                if (ss_s) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef SPI_SLAVE_MISO_EN
    // A new transmit byte starts at ss rise, or on the sclk fall that follows
    // the last sampled bit of the previous byte (counter has wrapped to 0).
    assign tx_start = (state_q == IDLE && ss_rise) ||
                      (state_q != IDLE && sclk_fall && cnt_q == 3'd0);

    always_comb begin
        tx_buf_d   = tx_buf_q;
        tx_sh_d    = tx_sh_q;
        tx_pend_d  = tx_pend_q;
        tx_ready_d = tx_ready_q;

        if (tx_start) begin
            tx_sh_d   = tx_pend_q ? tx_buf_q : '0;
            tx_pend_d = 1'b0;
        end else if (state_q != IDLE && sclk_fall) begin
            tx_sh_d = {tx_sh_q[SPI_DATA_W-2:0], 1'b0};
        end else if (state_d == IDLE && !ss_rise) begin
            tx_sh_d = '0;
        end

        // Buffer frees at byte completion, or when a frame is abandoned
        if (state_q == DONE || (state_q == SHIFT && state_d == IDLE)) begin
            tx_ready_d = 1'b1;
        end

        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_pend_d  = 1'b1;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf_q   <= '0;
            tx_sh_q    <= '0;
            tx_pend_q  <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            tx_buf_q   <= tx_buf_d;
            tx_sh_q    <= tx_sh_d;
            tx_pend_q  <= tx_pend_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign miso     = tx_sh_q[SPI_DATA_W-1];
    assign tx_ready = tx_ready_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_e_q    <= 1'b0;
            ss_e_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_e_q    <= sclk_s;
            ss_e_q      <= ss_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
// Self-checking bench for spi_slave_rx. clk period 10, sclk period 80 (8x).
// Expected bytes are queued as they are sent and popped on each rx_valid.
// Build with SPI_SLAVE_MISO_EN defined to include the transmit-path test.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       ss = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef SPI_SLAVE_MISO_EN
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       miso;
    logic       tx_ready;
`endif

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int fcnt = 0;
    int v0, f0;
    logic [7:0] exp_q[$];
    longint t_rise = 0;

    spi_slave_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
        .tx_data(tx_data), .tx_load(tx_load), .miso(miso), .tx_ready(tx_ready),
`endif
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rx_valid must match the oldest queued byte and arrive
    // 4 clk edges after the last sclk rise (sampled on the following negedge).
    always @(negedge clk) begin
        if (frame_err) fcnt++;
        if (rx_valid) begin
            vcnt++;
            chk("latency", 32'($time - t_rise), 32'd40);
`ifdef SPI_SLAVE_MISO_EN
            chk("tx_ready_at_valid", {31'd0, tx_ready}, 32'd1);
`endif
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // One sclk period per bit, MSB first; mosi changes while sclk is low.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #40;
            sclk = 1'b1;
            t_rise = $time;
            #40;
            sclk = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #52;
        @(negedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_MISO_EN
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_miso", {31'd0, miso}, 32'd0);
`endif
        rst = 1'b1;
        #40;

        // Single byte A5
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 8);
        #80;
        ss = 1'b0;
        #100;
        chk("a5_valids", 32'(vcnt - v0), 32'd1);
        chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_busy_low", {31'd0, busy}, 32'd0);

        // Three back-to-back bytes under one ss
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        send_bits(8'h01, 8);
        send_bits(8'h80, 8);
        send_bits(8'hFF, 8);
        #80;
        ss = 1'b0;
        #100;
        chk("b2b_valids", 32'(vcnt - v0), 32'd3);
        chk("b2b_frame_err", 32'(fcnt - f0), 32'd0);

        // Partial byte: 5 bits of 3C then ss drop
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        send_bits(8'h3C, 5);
        #40;
        ss = 1'b0;
        #100;
        chk("part_frame_err", 32'(fcnt - f0), 32'd1);
        chk("part_valids", 32'(vcnt - v0), 32'd0);
        chk("part_rx_data", {24'd0, rx_data}, 32'hFF);
        chk("part_busy", {31'd0, busy}, 32'd0);

        // sclk toggling with ss low: 16 edges, mosi high
        v0 = vcnt; f0 = fcnt;
        send_bits(8'hFF, 8);
        #100;
        chk("ssl_valids", 32'(vcnt - v0), 32'd0);
        chk("ssl_busy", {31'd0, busy}, 32'd0);
        chk("ssl_frame_err", 32'(fcnt - f0), 32'd0);

        // ss pulse with no bits sampled: no frame error, no byte
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        ss = 1'b0;
        #100;
        chk("zero_bits_ferr", 32'(fcnt - f0), 32'd0);
        chk("zero_bits_valids", 32'(vcnt - v0), 32'd0);

        // ss drops in the same cycle as the 8th sclk rise: byte completes
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        exp_q.push_back(8'h96);
        send_bits(8'h96, 7);
        mosi = 1'b0;
        #40;
        sclk = 1'b1;
        ss = 1'b0;
        t_rise = $time;
        #40;
        sclk = 1'b0;
        #100;
        chk("race_valids", 32'(vcnt - v0), 32'd1);
        chk("race_ferr", 32'(fcnt - f0), 32'd0);

        // Reset after 4 bits, then a full 5A transfer
        v0 = vcnt; f0 = fcnt;
        ss = 1'b1;
        #80;
        send_bits(8'hF0, 4);
        #20;
        rst = 1'b0;
        #20;
        ss = 1'b0;
        #40;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        #100;
        chk("rst_mid_ferr", 32'(fcnt - f0), 32'd0);
        chk("rst_mid_valids", 32'(vcnt - v0), 32'd0);
        chk("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
        ss = 1'b1;
        #80;
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 8);
        #80;
        ss = 1'b0;
        #100;
        chk("after_rst_valids", 32'(vcnt - v0), 32'd1);
        chk("after_rst_data", {24'd0, rx_data}, 32'h5A);

`ifdef SPI_SLAVE_MISO_EN
        // Transmit C3 while the master sends 00
        begin
            logic [7:0] txb;
            txb = 8'hC3;
            @(negedge clk);
            tx_data = txb;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            @(negedge clk);
            chk("tx_ready_low", {31'd0, tx_ready}, 32'd0);
            ss = 1'b1;
            #80;
            exp_q.push_back(8'h00);
            for (int i = 0; i < 8; i++) begin
                mosi = 1'b0;
                #40;
                chk($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, txb[7-i]});
                sclk = 1'b1;
                t_rise = $time;
                if (i == 7) begin
                    #20;
                    chk("tx_ready_before_done", {31'd0, tx_ready}, 32'd0);
                    #20;
                end else begin
                    #40;
                end
                sclk = 1'b0;
            end
            #80;
            chk("tx_ready_after", {31'd0, tx_ready}, 32'd1);
            ss = 1'b0;
            #100;
        end
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
